block_data_memory: RTL and testbench

BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

---
 rtl/block_data_memory.sv | 148 ++++++++++++++
 tb/tb_block_data_memory.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_data_memory.sv
// Block data memory: 64 x 32-bit blocks serving single-block reads/write-backs from the data cache.
// Latency: LATENCY edges from accept to completion; busywait drops for one cycle after completion.
// Backpressure: mem_busywait stalls the cache; requests are only sampled in IDLE (stats counters under DMEM_STATS_EN).
module block_data_memory #(
   parameter int LATENCY = 5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [5:0]  mem_address,
   input  logic [31:0] mem_writedata,
   output logic [31:0] mem_readdata,
   output logic        mem_busywait
`ifdef DMEM_STATS_EN
   ,
   output logic [15:0] read_count,
   output logic [15:0] write_count
`endif
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
   localparam bit         LAT_ONE = (LATENCY == 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_wr_q, op_wr_d;
   logic [5:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] readdata_q, readdata_d;
   logic [31:0] mem_q [64];

   logic        req_vld;
   logic        cmpl_rd;
   logic        cmpl_wr;
   logic [5:0]  cmpl_addr;
   logic [31:0] cmpl_data;

   // Both strobes high is a malformed request and is treated as no request.
   assign req_vld = mem_read ^ mem_write;

   // Next-state, completion and busywait decode; LATENCY==1 completes with live inputs at accept.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_wr_d      = op_wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      readdata_d   = readdata_q;
      cmpl_rd      = 1'b0;
      cmpl_wr      = 1'b0;
      cmpl_addr    = addr_q;
      cmpl_data    = wdata_q;
      mem_busywait = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_vld) begin
               mem_busywait = 1'b1;
               op_wr_d      = mem_write;
               addr_d       = mem_address;
               wdata_d      = mem_writedata;
               cnt_d        = LAT_M1;
               state_d      = ACCESS;
               if (LAT_ONE) begin
                  cmpl_rd   = mem_read;
                  cmpl_wr   = mem_write;
                  cmpl_addr = mem_address;
                  cmpl_data = mem_writedata;
               end
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               mem_busywait = 1'b1;
               cnt_d        = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  cmpl_rd = !op_wr_q;
                  cmpl_wr = op_wr_q;
               end
            end else begin
               // Completion cycle: return to IDLE without sampling a new request.
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (cmpl_rd) begin
         readdata_d = mem_q[cmpl_addr];
      end
   end

   // Control/data registers and storage array; reset clears everything and aborts any access.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         op_wr_q    <= 1'b0;
         addr_q     <= 6'd0;
         wdata_q    <= 32'd0;
         readdata_q <= 32'd0;
         for (int i = 0; i < 64; i++) begin
            mem_q[i] <= 32'd0;
         end
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_wr_q    <= op_wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         readdata_q <= readdata_d;
         if (cmpl_wr) begin
            mem_q[cmpl_addr] <= cmpl_data;
         end
      end
   end

   assign mem_readdata = readdata_q;

`ifdef DMEM_STATS_EN
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;

   // Saturating completion counters.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (cmpl_rd && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
      if (cmpl_wr && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_cnt_q <= 16'd0;
         wr_cnt_q <= 16'd0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign read_count  = rd_cnt_q;
   assign write_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// Testbench for block_data_memory: directed scenarios plus randomized traffic against an array model.
// Latency: checks busywait stays high LAT cycles per access, then low.
// Backpressure: inputs are dropped at the busywait-low cycle so each access returns to IDLE.
module tb_block_data_memory;

   localparam int LAT = 5;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        mem_read;
   logic        mem_write;
   logic [5:0]  mem_address;
   logic [31:0] mem_writedata;
   logic [31:0] mem_readdata;
   logic        mem_busywait;
`ifdef DMEM_STATS_EN
   logic [15:0] read_count;
   logic [15:0] write_count;
`endif

   int cmp_cnt = 0;
   int err_cnt = 0;

   logic [31:0] ref_mem [64];
   logic [31:0] ref_rd;
   int          ref_rc;
   int          ref_wc;

   block_data_memory #(.LATENCY(LAT)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_address   (mem_address),
      .mem_writedata (mem_writedata),
      .mem_readdata  (mem_readdata),
      .mem_busywait  (mem_busywait)
`ifdef DMEM_STATS_EN
      ,
      .read_count    (read_count),
      .write_count   (write_count)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;
      ref_rd = 32'd0;
      ref_rc = 0;
      ref_wc = 0;
   endtask

   task automatic model_apply(input bit rd, input logic [5:0] a, input logic [31:0] d);
      if (rd) begin
         ref_rd = ref_mem[a];
         ref_rc++;
      end else begin
         ref_mem[a] = d;
         ref_wc++;
      end
   endtask

   task automatic drop_inputs();
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = 6'd0;
      mem_writedata = 32'd0;
   endtask

   // Called just after the accept edge; walks to the busywait-low cycle and back to IDLE.
   task automatic wait_done(input string tag);
      int h;
      int n;
      h = 1;
      n = 0;
      @(negedge CLK);
      while (mem_busywait === 1'b1 && n < 40) begin
         h++;
         n++;
         @(negedge CLK);
      end
      drop_inputs();
      chk({tag, "_busy_len"}, h, LAT);
      chk({tag, "_readdata"}, mem_readdata, ref_rd);
      @(negedge CLK);
      chk({tag, "_idle_busy"}, mem_busywait, 1'b0);
   endtask

   // Issue one valid request at a negedge; optionally scramble inputs while in ACCESS.
   task automatic issue(input string tag, input bit rd, input logic [5:0] a,
                        input logic [31:0] d, input bit scr);
      mem_read      = rd;
      mem_write     = !rd;
      mem_address   = a;
      mem_writedata = d;
      #1;
      chk({tag, "_accept_busy"}, mem_busywait, 1'b1);
      model_apply(rd, a, d);
      @(posedge CLK);
      #1;
      if (scr) begin
         mem_read      = 1'($urandom);
         mem_write     = 1'($urandom);
         mem_address   = 6'($urandom);
         mem_writedata = $urandom;
      end
      wait_done(tag);
   endtask

   task automatic issue_both(input string tag, input logic [5:0] a, input logic [31:0] d);
      mem_read      = 1'b1;
      mem_write     = 1'b1;
      mem_address   = a;
      mem_writedata = d;
      #1;
      chk({tag, "_busy_now"}, mem_busywait, 1'b0);
      @(negedge CLK);
      chk({tag, "_busy_next"}, mem_busywait, 1'b0);
      chk({tag, "_readdata"}, mem_readdata, ref_rd);
      drop_inputs();
      @(negedge CLK);
   endtask

   task automatic pulse_reset();
      RESET = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      model_reset();
   endtask

   initial begin
      int r;
      logic [5:0]  a;
      logic [31:0] d;
      RESET = 1'b1;
      drop_inputs();
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_readdata", mem_readdata, 32'd0);
      chk("rst_busy", mem_busywait, 1'b0);
`ifdef DMEM_STATS_EN
      chk("rst_read_count", read_count, 32'd0);
      chk("rst_write_count", write_count, 32'd0);
`endif
      RESET = 1'b0;
      @(negedge CLK);

      // Read after reset returns zero.
      issue("rd00", 1'b1, 6'h00, 32'd0, 1'b0);
      // Write-back then fetch of the same block.
      issue("wr2a", 1'b0, 6'h2A, 32'hDEADBEEF, 1'b0);
      issue("rd2a", 1'b1, 6'h2A, 32'd0, 1'b0);
      chk("rd2a_value", mem_readdata, 32'hDEADBEEF);
      // Malformed request is ignored.
      issue_both("both10", 6'h10, 32'hFFFF_FFFF);
      issue("rd10", 1'b1, 6'h10, 32'd0, 1'b0);
      chk("rd10_value", mem_readdata, 32'd0);

      // Reset at the third edge of a write aborts it.
      mem_write     = 1'b1;
      mem_address   = 6'h05;
      mem_writedata = 32'h12345678;
      @(posedge CLK);
      @(negedge CLK);
      drop_inputs();
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      chk("rstmid_busy", mem_busywait, 1'b0);
      chk("rstmid_readdata", mem_readdata, 32'd0);
      @(negedge CLK);
      issue("rd05", 1'b1, 6'h05, 32'd0, 1'b0);
      chk("rd05_value", mem_readdata, 32'd0);

      // Inputs changing during ACCESS are ignored.
      issue("wr11", 1'b0, 6'h11, 32'hAAAA5555, 1'b1);
      issue("rd11", 1'b1, 6'h11, 32'd0, 1'b0);
      chk("rd11_value", mem_readdata, 32'hAAAA5555);
      issue("rd12", 1'b1, 6'h12, 32'd0, 1'b0);
      chk("rd12_value", mem_readdata, 32'd0);

      // Request held through reset release is accepted on the first edge after.
      issue("wr3f", 1'b0, 6'h3F, 32'hCAFEF00D, 1'b0);
      RESET         = 1'b1;
      mem_read      = 1'b1;
      mem_address   = 6'h3F;
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      #1;
      chk("held_accept_busy", mem_busywait, 1'b1);
      model_apply(1'b1, 6'h3F, 32'd0);
      @(posedge CLK);
      #1;
      wait_done("held");

      // Randomized traffic against the array model.
      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 9);
         a = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         d = $urandom;
         if (r == 0)      issue_both("rnd_both", a, d);
         else if (r < 5)  issue("rnd_rd", 1'b1, a, d, 1'($urandom));
         else             issue("rnd_wr", 1'b0, a, d, 1'($urandom));
      end

`ifdef DMEM_STATS_EN
      pulse_reset();
      issue("st_w0", 1'b0, 6'h01, 32'h1, 1'b0);
      issue("st_w1", 1'b0, 6'h02, 32'h2, 1'b0);
      issue("st_r0", 1'b1, 6'h01, 32'd0, 1'b0);
      issue("st_r1", 1'b1, 6'h02, 32'd0, 1'b0);
      issue("st_r2", 1'b1, 6'h03, 32'd0, 1'b0);
      chk("read_count", read_count, 32'(ref_rc));
      chk("write_count", write_count, 32'(ref_wc));
`endif

      // Reset clears the whole array and the read register.
      pulse_reset();
      chk("final_rst_readdata", mem_readdata, 32'd0);
`ifdef DMEM_STATS_EN
      chk("final_read_count", read_count, 32'd0);
      chk("final_write_count", write_count, 32'd0);
`endif
      for (int i = 0; i < 8; i++) begin
         issue("post_rst_rd", 1'b1, 6'(i), 32'd0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
